// File: rtl/branch_target_buffer_pkg.sv
// Shared constants for the branch target buffer:
// counter encodings, allocation value and datapath width.
package branch_target_buffer_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] CNT_SNT  = 2'b00;
    localparam logic [1:0] CNT_WNT  = 2'b01;
    localparam logic [1:0] CNT_WT   = 2'b10;
    localparam logic [1:0] CNT_ST   = 2'b11;
    localparam logic [1:0] CNT_INIT = CNT_WT;

endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch-side lookup and EX-side training bus of the BTB.
// The core is the master, the BTB is the slave.
interface branch_target_buffer_if;
    import branch_target_buffer_pkg::*;

    logic [XLEN-1:0] PC_IF;
    logic [XLEN-1:0] PredictPC;
    logic            PredictF;
    logic            br_EX;
    logic            br_taken_EX;
    logic [XLEN-1:0] PC_EX_br;
    logic [XLEN-1:0] br_target_EX;

    modport master (
        output PC_IF,
        output br_EX,
        output br_taken_EX,
        output PC_EX_br,
        output br_target_EX,
        input  PredictPC,
        input  PredictF
    );

    modport slave (
        input  PC_IF,
        input  br_EX,
        input  br_taken_EX,
        input  PC_EX_br,
        input  br_target_EX,
        output PredictPC,
        output PredictF
    );
endinterface

// File: rtl/branch_target_buffer_sat_counter2.sv
// Next-state of a 2-bit saturating direction counter.
// Saturates at strong-taken and strong-not-taken.
module sat_counter2
    import branch_target_buffer_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_nxt
);
    always_comb begin
        cnt_nxt = cnt;
        if (taken) begin
            if (cnt != CNT_ST) cnt_nxt = cnt + 2'd1;
        end else begin
            if (cnt != CNT_SNT) cnt_nxt = cnt - 2'd1;
        end
    end
endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit counters: async lookup in IF,
// training from resolved conditional branches in EX.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bubbleD,
    input  logic                          flushD,
    input  logic                          bubbleE,
    input  logic                          flushE,
    branch_target_buffer_if.slave         bus,
    output logic                          PredictE
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = XLEN - INDEX_BITS - 2;

    logic            valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [XLEN-1:0] target_q [ENTRIES];
    logic [1:0]      cnt_q    [ENTRIES];

    logic [INDEX_BITS-1:0] if_idx;
    logic [INDEX_BITS-1:0] ex_idx;
    logic [TAG_W-1:0]      if_tag;
    logic [TAG_W-1:0]      ex_tag;
    logic                  if_hit;
    logic                  ex_hit;
    logic                  upd;
    logic [1:0]            cnt_nxt;
    logic                  predict_d;
    logic                  unused_pc_lsb;

    assign if_idx = bus.PC_IF[INDEX_BITS+1:2];
    assign if_tag = bus.PC_IF[XLEN-1:INDEX_BITS+2];
    assign ex_idx = bus.PC_EX_br[INDEX_BITS+1:2];
    assign ex_tag = bus.PC_EX_br[XLEN-1:INDEX_BITS+2];

    assign unused_pc_lsb = ^{bus.PC_IF[1:0], bus.PC_EX_br[1:0]};

    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    assign bus.PredictF  = if_hit && cnt_q[if_idx][1];
    assign bus.PredictPC = bus.PredictF ? target_q[if_idx] : '0;

    // A stalled EX holds the same branch, so train only when it moves on.
    assign upd = bus.br_EX && !bubbleE;

    sat_counter2 u_sat_counter2 (
        .cnt     (cnt_q[ex_idx]),
        .taken   (bus.br_taken_EX),
        .cnt_nxt (cnt_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
        end else if (upd) begin
            if (ex_hit) begin
                cnt_q[ex_idx] <= cnt_nxt;
                if (bus.br_taken_EX) target_q[ex_idx] <= bus.br_target_EX;
            end else if (bus.br_taken_EX) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= bus.br_target_EX;
                cnt_q[ex_idx]    <= CNT_INIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            predict_d <= 1'b0;
            PredictE  <= 1'b0;
        end else begin
            if (!bubbleD) predict_d <= flushD ? 1'b0 : bus.PredictF;
            if (!bubbleE) PredictE  <= flushE ? 1'b0 : predict_d;
        end
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed table,
// hand-written pipeline/reset sequences, and a randomized model run.
module tb_branch_target_buffer;
    logic clk = 1'b0;
    logic rst, bubbleD, flushD, bubbleE, flushE, PredictE;

    branch_target_buffer_if bus ();

    branch_target_buffer #(.INDEX_BITS(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .bubbleD  (bubbleD),
        .flushD   (flushD),
        .bubbleE  (bubbleE),
        .flushE   (flushE),
        .bus      (bus.slave),
        .PredictE (PredictE)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference table: one record per index, counter kept as an int 0..3.
    bit          m_valid [64];
    int unsigned m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_cnt   [64];
    bit          m_pd, m_pe;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic void m_lookup(logic [31:0] pc, output bit f,
                                     output logic [31:0] t);
        int idx = int'((pc >> 2) & 32'h3f);
        f = m_valid[idx] && (m_tag[idx] == (pc >> 8)) && (m_cnt[idx] >= 2);
        t = f ? m_tgt[idx] : 32'h0;
    endfunction

    function automatic void m_train(logic [31:0] pc, bit tk,
                                    logic [31:0] tgt);
        int idx = int'((pc >> 2) & 32'h3f);
        if (m_valid[idx] && m_tag[idx] == (pc >> 8)) begin
            if (tk) begin
                m_cnt[idx] = (m_cnt[idx] + 1 > 3) ? 3 : m_cnt[idx] + 1;
                m_tgt[idx] = tgt;
            end else begin
                m_cnt[idx] = (m_cnt[idx] - 1 < 0) ? 0 : m_cnt[idx] - 1;
            end
        end else if (tk) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = pc >> 8;
            m_tgt[idx]   = tgt;
            m_cnt[idx]   = 2;
        end
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        bit f;
        logic [31:0] t;
        m_lookup(bus.PC_IF, f, t);
        if (rst) begin
            for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
            m_pd = 1'b0;
            m_pe = 1'b0;
        end else begin
            if (!bubbleE) m_pe = flushE ? 1'b0 : m_pd;
            if (!bubbleD) m_pd = flushD ? 1'b0 : f;
            if (bus.br_EX && !bubbleE)
                m_train(bus.PC_EX_br, bus.br_taken_EX, bus.br_target_EX);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(bit br, bit tk, logic [31:0] pc,
                           logic [31:0] tgt);
        bus.br_EX        = br;
        bus.br_taken_EX  = tk;
        bus.PC_EX_br     = pc;
        bus.br_target_EX = tgt;
    endtask

    typedef struct {
        bit          br;
        bit          tk;
        logic [31:0] pc_ex;
        logic [31:0] tgt;
        logic [31:0] pc_lk;
        bit          exp_f;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [15];

    initial begin
        bit f;
        logic [31:0] t;

        vecs[0]  = '{1, 1, 32'h040, 32'h100, 32'h040, 1, 32'h100};
        vecs[1]  = '{1, 0, 32'h040, 32'h999, 32'h040, 0, 32'h0};
        vecs[2]  = '{1, 0, 32'h040, 32'h999, 32'h040, 0, 32'h0};
        vecs[3]  = '{1, 1, 32'h040, 32'h100, 32'h040, 0, 32'h0};
        vecs[4]  = '{1, 1, 32'h040, 32'h100, 32'h040, 1, 32'h100};
        vecs[5]  = '{1, 1, 32'h040, 32'h200, 32'h040, 1, 32'h200};
        vecs[6]  = '{1, 1, 32'h040, 32'h200, 32'h040, 1, 32'h200};
        vecs[7]  = '{1, 1, 32'h040, 32'h200, 32'h040, 1, 32'h200};
        vecs[8]  = '{1, 0, 32'h040, 32'h300, 32'h040, 1, 32'h200};
        vecs[9]  = '{1, 0, 32'h040, 32'h300, 32'h040, 0, 32'h0};
        vecs[10] = '{1, 1, 32'h140, 32'h500, 32'h040, 0, 32'h0};
        vecs[11] = '{0, 0, 32'h000, 32'h000, 32'h140, 1, 32'h500};
        vecs[12] = '{1, 0, 32'h240, 32'h600, 32'h140, 1, 32'h500};
        vecs[13] = '{0, 0, 32'h000, 32'h000, 32'h240, 0, 32'h0};
        vecs[14] = '{1, 0, 32'h080, 32'h700, 32'h080, 0, 32'h0};

        rst = 1'b1;
        bubbleD = 0; flushD = 0; bubbleE = 0; flushE = 0;
        bus.PC_IF = 32'h0;
        set_upd(0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        bus.PC_IF = 32'h40;
        #1;
        chk("reset_predf", {31'b0, bus.PredictF}, 32'h0);
        chk("reset_predpc", bus.PredictPC, 32'h0);
        chk("reset_prede", {31'b0, PredictE}, 32'h0);

        foreach (vecs[i]) begin
            set_upd(vecs[i].br, vecs[i].tk, vecs[i].pc_ex, vecs[i].tgt);
            tick();
            set_upd(0, 0, 0, 0);
            bus.PC_IF = vecs[i].pc_lk;
            #1;
            chk($sformatf("vec%0d_predf", i), {31'b0, bus.PredictF},
                {31'b0, vecs[i].exp_f});
            chk($sformatf("vec%0d_predpc", i), bus.PredictPC, vecs[i].exp_pc);
        end

        // Same-cycle lookup and update: pre-update contents, no bypass.
        bus.PC_IF = 32'h0C0;
        set_upd(1, 1, 32'h0C0, 32'hABC);
        #1;
        chk("nobypass_predf", {31'b0, bus.PredictF}, 32'h0);
        tick();
        set_upd(0, 0, 0, 0);
        #1;
        chk("after_alloc_predpc", bus.PredictPC, 32'hABC);

        // Pipeline: predicted fetch reaches EX two edges later.
        bus.PC_IF = 32'h140;
        tick();
        bus.PC_IF = 32'h0;
        tick();
        chk("prede_aligned", {31'b0, PredictE}, 32'h1);
        bubbleE = 1'b1;
        set_upd(1, 0, 32'h140, 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("prede_hold%0d", c), {31'b0, PredictE}, 32'h1);
        end
        bubbleE = 1'b0;
        tick();
        set_upd(0, 0, 0, 0);
        bus.PC_IF = 32'h140;
        #1;
        chk("one_update_nt", {31'b0, bus.PredictF}, 32'h0);
        set_upd(1, 1, 32'h140, 32'h500);
        tick();
        set_upd(0, 0, 0, 0);
        #1;
        chk("one_update_t", {31'b0, bus.PredictF}, 32'h1);
        tick();
        bus.PC_IF = 32'h0;
        tick();
        chk("prede_before_flush", {31'b0, PredictE}, 32'h1);
        flushE = 1'b1;
        tick();
        flushE = 1'b0;
        chk("prede_flushed", {31'b0, PredictE}, 32'h0);

        // Reset concurrent with a taken update discards the update.
        rst = 1'b1;
        set_upd(1, 1, 32'h080, 32'h800);
        tick();
        rst = 1'b0;
        set_upd(0, 0, 0, 0);
        bus.PC_IF = 32'h080;
        #1;
        chk("rst_upd_predf", {31'b0, bus.PredictF}, 32'h0);
        chk("rst_upd_predpc", bus.PredictPC, 32'h0);
        bus.PC_IF = 32'h140;
        #1;
        chk("rst_clears_140", {31'b0, bus.PredictF}, 32'h0);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            logic [31:0] pool [6];
            pool[0] = 32'h040; pool[1] = 32'h140; pool[2] = 32'h080;
            pool[3] = 32'h044; pool[4] = 32'h0C0;
            pool[5] = {$urandom} & 32'hFFFF_FFFC;
            rst     = ($urandom_range(0, 99) == 0);
            bubbleD = ($urandom_range(0, 4) == 0);
            flushD  = ($urandom_range(0, 6) == 0);
            bubbleE = ($urandom_range(0, 4) == 0);
            flushE  = ($urandom_range(0, 6) == 0);
            bus.PC_IF = pool[$urandom_range(0, 5)];
            set_upd($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    pool[$urandom_range(0, 4)], {$urandom} & 32'hFFFF_FFFC);
            #1;
            m_lookup(bus.PC_IF, f, t);
            chk("rnd_predf", {31'b0, bus.PredictF}, {31'b0, f});
            chk("rnd_predpc", bus.PredictPC, t);
            chk("rnd_prede", {31'b0, PredictE}, {31'b0, m_pe});
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer with 2-bit saturating direction counters for the RV32I pipelined core. Sits in the IF stage. It looks up the current fetch PC and produces `PredictPC`/`PredictF` for NPC generation. It carries each prediction down the pipeline to EX as `PredictE`. When a conditional branch resolves in EX, it trains its table from that branch's outcome. It is the producer side of the prediction signals that NPC generation consumes.

## Interface
- `INDEX_BITS`, 6: log2 of entry count (64 entries); index = `PC[INDEX_BITS+1:2]`.
- `clk`  in  1  core clock.
- `rst`  in  1  reset. Synchronous, active-high; one clock, no other clock domains.
- `PC_IF`  in  32  address of the instruction being fetched.
- `bubbleD`, `flushD`  in  1 each  ID-stage register hold / clear.
- `bubbleE`, `flushE`  in  1 each  EX-stage register hold / clear.
- `br_EX`  in  1  instruction in EX is a conditional branch.
- `br_taken_EX`  in  1  resolved direction of that branch.
- `PC_EX_br`  in  32  address of the branch in EX.
- `br_target_EX`  in  32  resolved taken target of that branch.
- `PredictPC`  out  32  predicted target for `PC_IF`.
- `PredictF`  out  1  predict-taken for `PC_IF`.
- `PredictE`  out  1  prediction made earlier for the instruction now in EX.

## Operation
- **Entry contents**
  - `valid` (1 bit), `tag` = `PC[31:INDEX_BITS+2]` (24 bits at default), `target` (32 bits), `cnt` (2 bits).
  - Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- **Lookup (combinational from `PC_IF`)**
  - hit = `valid` && tag match.
  - `PredictF` = hit && `cnt[1]`.
  - `PredictPC` = `target` when `PredictF`=1, else 0.
- **Prediction pipeline**
  - `PredictD` register:
    - `bubbleD`: hold.
    - Else `flushD`: 0.
    - Else: load `PredictF`.
  - `PredictE` register follows the same rules using `bubbleE`/`flushE`, loading from `PredictD`.
  - Bubble has priority over flush, matching the core's stage registers.
- **Update**
  - Enable: `upd` = `br_EX` && !`bubbleE`. This trains once per branch even when EX stalls.
  - Hit at `PC_EX_br`, taken:
    - `cnt` = min(`cnt`+1, 3).
    - `target` <= `br_target_EX`.
  - Hit, not taken: `cnt` = max(`cnt`-1, 0); `target` unchanged.
  - Miss, taken (allocate/replace):
    - `valid`=1, `tag` from `PC_EX_br`, `target`=`br_target_EX`, `cnt`=10.
  - Miss, not taken: no write.
- **Restrictions**
  - Non-branches are never allocated. `jal` and `jalr` are not trained.
- **Reset**
  - All `valid` cleared; `PredictD`=0, `PredictE`=0.
  - Consequently `PredictF`=0 and `PredictPC`=0 on the first cycle after reset.
  - `tag`/`target`/`cnt` need not be cleared.

## Timing
- Lookup is zero-latency, combinational in the same cycle as `PC_IF`.
- Update is written at the rising edge that ends the cycle in which `upd`=1. It is visible to lookup from the next cycle.
- Same-cycle lookup and update of one index: lookup returns pre-update contents. There is no bypass.
- `PredictE` is valid two edges after the fetch that produced it, absent stalls. It stays aligned with the EX instruction under any bubble/flush pattern.
- `rst` asserted mid-operation:
  - Table invalidated and prediction registers zeroed at that edge.
  - A concurrent `upd` is discarded.
  - `rst` has priority over all other inputs.
- Counter saturation: 11 + taken stays 11; 00 + not-taken stays 00. No wrap.
- Tag aliasing: a different tag at the same index is a miss and is overwritten only on a taken branch.

## Structure
- Shared core package holds:
  - Counter encoding constants: `CNT_SNT`, `CNT_WNT`, `CNT_WT`, `CNT_ST`.
  - Allocation value `CNT_INIT`=`CNT_WT`.
  - `XLEN`=32.
- One natural sub-module: `sat_counter2`, a combinational next-state function of (`cnt`, `taken`).
- Table storage uses flop arrays rather than BRAM, because lookup must be asynchronous and reset must clear `valid`.

## Test plan
- Reset, then `PC_IF`=0x0000_0040 → `PredictF`=0, `PredictPC`=0, `PredictE`=0.
- Update `br_EX`=1, taken, `PC_EX_br`=0x40, target 0x100; next cycle `PC_IF`=0x40 → `PredictF`=1, `PredictPC`=0x100. Two further not-taken updates → `PredictF`=0 (`cnt` 10→01→00). One taken → still 0 (01).
- Four taken updates at 0x40 then one not-taken → `cnt` 11→10, `PredictF` stays 1. The not-taken update leaves `target` unchanged.
- Aliasing: entry at 0x40 valid; taken update at 0x140 (same index at `INDEX_BITS`=6, different tag) → lookup 0x40 misses (`PredictF`=0) and 0x140 hits. A not-taken update at 0x240 writes nothing.
- Pipeline: predicted-taken fetch, then `bubbleE`=1 for 3 cycles with `br_EX`=1 → `PredictE` held at 1 and exactly one counter update. Then `flushE`=1 → `PredictE`=0 next edge.
- `rst` asserted in the same cycle as a taken update at 0x80 → after reset, lookup 0x80 gives `PredictF`=0.
